// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared types and constants for the stream round-robin arbiter
package stream_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/stream_rr_pick.sv
// stream_rr_pick: combinational cyclic priority picker
module stream_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_mode,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);
  int w_start;
  // scan from the highest offset down so the nearest requester wins last
  always_comb begin
    w_start = i_mode ? 0 : (int'(i_ptr) + 1) % N;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[(w_start + i) % N]) begin
        o_idx = IDW'((w_start + i) % N);
        o_any = 1'b1;
      end
  end
  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: N-to-1 valid/ready arbiter with packet lock and registered output
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ARB_MODE   = 0,
  parameter int PKT_LOCK   = 1,
  localparam int IDW       = idw(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid_i,
  output logic [NUM_REQ-1:0]            in_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_REQ-1:0]            in_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_last_o,
  output logic [IDW-1:0]                out_id_o,
  output logic                          busy_o
);
  arb_state_e r_state, w_state_nxt;
  logic [IDW-1:0] r_lock_id, r_ptr, w_idx;
  logic [NUM_REQ-1:0] w_req, w_gnt;
  logic w_any, w_can, w_acc, w_last;
  assign w_can  = ~out_valid_o | out_ready_i;
  // while locked, only the owning requester is visible to the picker
  assign w_req  = (r_state == ARB_LOCKED) ? (in_valid_i & (NUM_REQ'(1) << r_lock_id)) : in_valid_i;
  assign w_acc  = w_can & w_any;
  assign w_last = in_last_i[w_idx];
  assign in_ready_o = w_can ? w_gnt : '0;
  assign busy_o = (r_state == ARB_LOCKED);
  stream_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .i_mode (ARB_MODE == ARB_FIXED),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );
  always_comb begin
    w_state_nxt = r_state;
    if (PKT_LOCK != 0 && w_acc) w_state_nxt = w_last ? ARB_IDLE : ARB_LOCKED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_lock_id   <= '0;
      r_ptr       <= IDW'(NUM_REQ - 1);
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_id_o    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) r_lock_id <= w_idx;
      if (w_acc && (PKT_LOCK == 0 || w_last)) r_ptr <= w_idx;
      if (w_acc) begin
        out_valid_o <= 1'b1;
        out_data_o  <= in_data_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
        out_last_o  <= w_last;
        out_id_o    <= w_idx;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
        out_last_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: randomized check of the arbiter against a packet-level reference model
module tb_stream_rr_arbiter;
  localparam int N = 4, W = 8, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] in_valid, in_ready, in_last;
  logic [N*W-1:0] in_data;
  logic out_valid, out_ready, out_last, busy;
  logic [W-1:0] out_data;
  logic [IDW-1:0] out_id;
  logic [N-1:0] fp_ready;
  logic fp_valid, fp_last, fp_busy;
  logic [W-1:0] fp_data;
  logic [IDW-1:0] fp_id;
  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ARB_MODE(0), .PKT_LOCK(1)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_last_i(in_last), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .out_id_o(out_id), .busy_o(busy)
  );
  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ARB_MODE(1), .PKT_LOCK(1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid_i(4'b1111), .in_ready_o(fp_ready), .in_data_i(32'h13121110),
    .in_last_i(4'b1111), .out_valid_o(fp_valid), .out_ready_i(1'b1), .out_data_o(fp_data),
    .out_last_o(fp_last), .out_id_o(fp_id), .busy_o(fp_busy)
  );
  int n_cmp = 0, n_bad = 0;
  int m_ptr, m_lid, m_oid, last_win, fp_cyc, cyc_dir;
  bit m_lock, m_ov, m_ol, last_acc, rst_done;
  logic [W-1:0] m_od;
  bit v[N], l[N];
  logic [W-1:0] d[N];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic pack();
    for (int k = 0; k < N; k++) begin
      in_valid[k] = v[k];
      in_last[k] = l[k];
      in_data[k*W +: W] = d[k];
    end
  endtask
  task automatic model_reset();
    m_ptr = N - 1; m_lid = 0; m_oid = 0; m_lock = 0; m_ov = 0; m_ol = 0; m_od = '0;
    last_acc = 0; last_win = 0; fp_cyc = 0; cyc_dir = 8;
    for (int k = 0; k < N; k++) begin v[k] = 0; l[k] = 0; d[k] = '0; end
  endtask
  task automatic step();
    int win;
    bit can, found, dir;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("out_id", 32'(out_id), 32'(m_oid));
    chk("busy", 32'(busy), 32'(m_lock));
    chk("fp_ready", 32'(fp_ready), 32'h1);
    chk("fp_id", 32'(fp_id), 32'h0);
    chk("fp_data", 32'(fp_data), fp_cyc > 0 ? 32'h10 : 32'h0);
    fp_cyc++;
    dir = cyc_dir > 0;
    if (dir) cyc_dir--;
    // requesters hold a beat until it is taken, then maybe offer the next one
    for (int k = 0; k < N; k++) begin
      if (dir) begin
        v[k] = 1; l[k] = 1; d[k] = 8'(8'h10 + k);
      end else if (last_acc && last_win == k) begin
        v[k] = 1'($urandom % 2); d[k] = 8'($urandom); l[k] = ($urandom % 3) == 0;
      end else if (!v[k] && ($urandom % 10) < 3) begin
        v[k] = 1; d[k] = 8'($urandom); l[k] = ($urandom % 3) == 0;
      end
    end
    out_ready = dir ? 1'b1 : (($urandom % 10) < 7);
    pack();
    #1;
    can = !m_ov || out_ready;
    found = 0;
    win = 0;
    if (m_lock) begin
      found = v[m_lid];
      win = m_lid;
    end else begin
      for (int i = 1; i <= N; i++) begin
        int j = (m_ptr + i) % N;
        if (!found && v[j]) begin found = 1; win = j; end
      end
    end
    chk("in_ready", 32'(in_ready), (can && found) ? (32'h1 << win) : 32'h0);
    last_acc = can && found;
    last_win = win;
    if (last_acc) begin
      m_ov = 1; m_od = d[win]; m_ol = l[win]; m_oid = win;
      if (l[win]) begin m_lock = 0; m_ptr = win; end
      else begin m_lock = 1; m_lid = win; end
    end else if (m_ov && out_ready) begin
      m_ov = 0; m_od = '0; m_ol = 0;
    end
    @(negedge clk);
  endtask
  initial begin
    out_ready = 1'b0;
    model_reset();
    pack();
    rst_done = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 1500 && !rst_done && m_lock) begin
        rst_done = 1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_id", 32'(out_id), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pack();
      end
      step();
    end
    chk("lock_reset_seen", 32'(rst_done), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
